sram_pipe: RTL and testbench
============================

SRAM_PIPE -- requirements
Module: sram_pipe

Interface
REQ-001 Parameter WORD_AMOUNT, default 56, number of words.
REQ-002 Parameter BIT_PER_WORD, default 129, word width in bits.
REQ-003 Parameter SEG_W, default 129, write-mask segment width. NSEG = ceil(BIT_PER_WORD/SEG_W). The last segment may be partial.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles. Legal range 1..3; any other value is an elaboration error.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request can be accepted this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  $clog2(WORD_AMOUNT)  word address.
REQ-011 req_wdata  in  BIT_PER_WORD  write data.
REQ-012 req_wmask  in  NSEG  per-segment write enable.
REQ-013 rsp_valid  out  1  read data present.
REQ-014 rsp_ready  in  1  consumer accepts read data.
REQ-015 rsp_data  out  BIT_PER_WORD  read data.
REQ-016 busy  out  1  initial clear sweep in progress.

Function
REQ-017 A request is accepted on a posedge where req_valid && req_ready.
REQ-018 Accepted write: only segments with a req_wmask bit = 1 are updated, on the accept edge. A write produces no response.
REQ-019 Accepted read: the word is captured on the accept edge and delivered on rsp_data RD_LAT cycles later, with rsp_valid = 1 when the output is unstalled. A read accepted on the cycle after a write to the same address returns the new data.
REQ-020 Responses are returned in acceptance order.
REQ-021 While rsp_valid && !rsp_ready, rsp_data and rsp_valid hold stable.
REQ-022 Credit rule: req_ready = !busy && (in-flight reads + output-FIFO occupancy < RD_LAT+1). Throughput never drops below this and no response is ever lost.
REQ-023 Output FIFO depth is RD_LAT+1. It supports push and pop in the same cycle, including when full.
REQ-024 req_addr >= WORD_AMOUNT: a write is dropped; a read returns all-zero data and still produces a response.
REQ-025 req_ready is independent of req_valid; there is no combinational path from req_valid to req_ready.
REQ-026 With rsp_ready held at 1, back-to-back reads sustain one response per cycle.

Reset
REQ-027 rst=1 forces rsp_valid=0, empties the FIFO and the read pipeline, and makes req_ready=0; this happens immediately, without waiting for clk.
REQ-028 After rst deasserts: with the clear sweep compiled in, req_ready goes to 1 when the sweep completes; otherwise req_ready=1 on the first posedge after deassertion.
REQ-029 Memory contents are not reset by rst except through the clear sweep.
REQ-030 rst asserted during a sweep aborts it. The sweep restarts from address 0 after rst deasserts.

Configuration
REQ-031 Macro SRAM_PIPE_CLEAR_EN. When defined, an FSM with states IDLE and CLEAR is present.
- On rst deassert the FSM enters CLEAR.
- In CLEAR it writes zero to one address per cycle, from 0 to WORD_AMOUNT-1, with busy=1.
- It then moves to IDLE with busy=0. The sweep takes WORD_AMOUNT cycles.
REQ-032 When SRAM_PIPE_CLEAR_EN is undefined, no FSM is present, busy is tied 0, and memory powers up undefined.

Structure
REQ-033 Package sram_pipe_pkg holds the FSM state enum, RD_LAT_MAX=3, and the NSEG helper function.
REQ-034 The output FIFO is sub-module sram_rsp_fifo, parametrised by width and depth.
REQ-035 The memory array, the RD_LAT-stage read pipeline and the credit counter stay in sram_pipe.

Verification
REQ-036 Write addr 5 = 129'h1_DEAD..BEEF with a full mask, then read addr 5 with rsp_ready=1. Required: the data appears exactly RD_LAT cycles after the read is accepted.
REQ-037 With SEG_W=64 (NSEG=3), write all-ones, then all-zeros with mask 3'b010. Required: a read returns bits [127:64]=0 and all other bits 1.
REQ-038 With RD_LAT=2, hold rsp_ready=0 and issue reads continuously. Required:
- req_ready drops after exactly 3 accepted reads.
- When rsp_ready is released, the 3 responses drain in order, one per cycle.
REQ-039 Read addr 60. Required: rsp_data=0 and rsp_valid is asserted. Write addr 60. Required: no memory word changes.
REQ-040 With SRAM_PIPE_CLEAR_EN defined, assert rst at sweep cycle 20. Required: busy stays 1 for 56 full cycles after release; all words then read 0; req_ready rises the cycle busy falls.
REQ-041 Assert rst while 2 reads are in flight. Required: rsp_valid=0 immediately and no stale response appears after release.

Source files
------------

// File: rtl/sram_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sram_pipe_pkg
// Shared definitions for the sram_pipe block:
//   RD_LAT_MAX  - largest supported read latency
//   clr_state_t - state encoding of the optional power-up clear sweep FSM
//   nseg()      - number of write-mask segments for a word/segment width pair
// -----------------------------------------------------------------------------
package sram_pipe_pkg;

    localparam int RD_LAT_MAX = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // ceil(bits / seg_w); the last segment may be narrower than seg_w.
    function automatic int nseg(input int bits, input int seg_w);
        return (bits + seg_w - 1) / seg_w;
    endfunction

endpackage

// File: rtl/sram_pipe_if.sv
// -----------------------------------------------------------------------------
// sram_pipe_if
// Request/response bus of sram_pipe.
//   req_valid/req_ready  request handshake (master -> slave)
//   req_we               1 = write, 0 = read
//   req_addr             word address
//   req_wdata/req_wmask  write data and per-segment write enable
//   rsp_valid/rsp_ready  read response handshake (slave -> master)
//   rsp_data             read data
//   busy                 power-up clear sweep in progress
// Modports: master (requester side), slave (memory side).
// -----------------------------------------------------------------------------
interface sram_pipe_if
    import sram_pipe_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 129,
    parameter int SEG_W  = 129,
    parameter int NSEG   = nseg(DATA_W, SEG_W)
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NSEG-1:0]   req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/sram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Small synchronous FIFO holding read responses until the consumer takes them.
// Output is presented straight from storage, so an entry is visible in the
// cycle after it is pushed. Push and pop in the same cycle are allowed even
// when full (the popped slot is reused).
// Ports:
//   clk, rst              clock, asynchronous active-high reset (empties FIFO)
//   push, push_data       write side
//   pop                   consume the head entry (only meaningful when valid)
//   out_valid, out_data   head entry
// -----------------------------------------------------------------------------
module sram_rsp_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = store[rd_ptr];
    assign do_pop    = pop && out_valid;
    assign do_push   = push && (!full || do_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_pipe.sv
// -----------------------------------------------------------------------------
// sram_pipe
// Single-port word memory with per-segment write mask, a fixed-latency read
// pipeline (RD_LAT cycles) and a response FIFO with credit-based flow control.
// Ports:
//   clk   sole clock
//   rst   asynchronous active-high reset of all control state (not memory)
//   bus   sram_pipe_if.slave: request, response and busy signals
// Parameters: WORD_AMOUNT, BIT_PER_WORD, SEG_W, RD_LAT (1..RD_LAT_MAX).
// Build option: define SRAM_PIPE_CLEAR_EN to add the power-up clear sweep
// (IDLE/CLEAR FSM zeroing every word after reset, with busy high meanwhile).
// -----------------------------------------------------------------------------
module sram_pipe
    import sram_pipe_pkg::*;
#(
    parameter int WORD_AMOUNT  = 56,
    parameter int BIT_PER_WORD = 129,
    parameter int SEG_W        = 129,
    parameter int RD_LAT       = 1
) (
    input  logic       clk,
    input  logic       rst,
    sram_pipe_if.slave bus
);

    localparam int              NSEG     = nseg(BIT_PER_WORD, SEG_W);
    localparam int              ADDR_W   = (WORD_AMOUNT > 1) ? $clog2(WORD_AMOUNT) : 1;
    localparam int              CRED_MAX = RD_LAT + 1;
    localparam int              CNT_W    = $clog2(CRED_MAX + 1);
    localparam logic [ADDR_W:0] WORDS    = WORD_AMOUNT[ADDR_W:0];

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("sram_pipe: RD_LAT must be within 1..%0d", RD_LAT_MAX);
    end

    logic [BIT_PER_WORD-1:0] mem [WORD_AMOUNT];

    logic                    accept;
    logic                    addr_ok;
    logic                    acc_rd;
    logic                    pop;
    logic                    ready_en;
    logic                    credit_ok;
    logic [CNT_W-1:0]        cred_cnt;

    logic                    sweep_we;
    logic [ADDR_W-1:0]       sweep_addr;

    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [BIT_PER_WORD-1:0] wr_data;
    logic [NSEG-1:0]         wr_mask;

    logic                    rd_vld_p0;
    logic [BIT_PER_WORD-1:0] rd_data_p0;
    logic                    fifo_push;
    logic [BIT_PER_WORD-1:0] fifo_push_data;

    assign accept  = bus.req_valid && bus.req_ready;
    assign addr_ok = ({1'b0, bus.req_addr} < WORDS);
    assign acc_rd  = accept && !bus.req_we;
    assign pop     = bus.rsp_valid && bus.rsp_ready;

    // cred_cnt counts every accepted read not yet popped, i.e. reads in the
    // pipeline plus FIFO occupancy. Holding it below the FIFO depth means the
    // pipeline never needs to stall, so it carries no backpressure at all.
    assign credit_ok     = (cred_cnt < CNT_W'(CRED_MAX));
    assign bus.req_ready = ready_en && credit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred_cnt <= '0;
        end else if (acc_rd && !pop) begin
            cred_cnt <= cred_cnt + 1'b1;
        end else if (!acc_rd && pop) begin
            cred_cnt <= cred_cnt - 1'b1;
        end
    end

`ifdef SRAM_PIPE_CLEAR_EN
    clr_state_t        state;
    logic              busy_r;
    logic [ADDR_W-1:0] clr_addr;

    // Reset parks the FSM in CLEAR at address 0, so the sweep starts on the
    // first edge after release and restarts from 0 if reset hits mid-sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            busy_r   <= 1'b1;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == ADDR_W'(WORD_AMOUNT - 1)) begin
                        state    <= IDLE;
                        busy_r   <= 1'b0;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Edges seen while rst is held rewrite word 0 with zero; the sweep that
    // follows zeroes it anyway.
    assign sweep_we   = busy_r;
    assign sweep_addr = clr_addr;
    assign bus.busy   = busy_r;
    assign ready_en   = !busy_r;
`else
    logic run;

    // Requests open on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run <= 1'b0;
        else     run <= 1'b1;
    end

    assign sweep_we   = 1'b0;
    assign sweep_addr = '0;
    assign bus.busy   = 1'b0;
    assign ready_en   = run;
`endif

    // Single write port shared by the clear sweep and accepted writes; the two
    // never coincide because req_ready is low while the sweep runs.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.req_addr;
        wr_data = bus.req_wdata;
        wr_mask = bus.req_wmask;
        if (sweep_we) begin
            wr_en   = 1'b1;
            wr_addr = sweep_addr;
            wr_data = '0;
            wr_mask = '1;
        end else if (accept && bus.req_we && addr_ok) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BIT_PER_WORD; b++) begin
                if (wr_mask[b / SEG_W]) mem[wr_addr][b] <= wr_data[b];
            end
        end
    end

    // ---- p0: array read at the accept edge ----
    // A write on the previous edge is already in mem, so read-after-write
    // returns the new word without forwarding.
    assign rd_vld_p0  = acc_rd;
    assign rd_data_p0 = addr_ok ? mem[bus.req_addr] : '0;

    if (RD_LAT == 1) begin : g_lat1
        assign fifo_push      = rd_vld_p0;
        assign fifo_push_data = rd_data_p0;
    end else begin : g_latn
        logic                    vld_p  [1:RD_LAT-1];
        logic [BIT_PER_WORD-1:0] data_p [1:RD_LAT-1];

        // ---- p1..p(RD_LAT-1): delay stages; the FIFO is the last stage ----
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 1; i < RD_LAT; i++) vld_p[i] <= 1'b0;
            end else begin
                vld_p[1] <= rd_vld_p0;
                for (int i = 2; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
            end
        end

        always_ff @(posedge clk) begin
            data_p[1] <= rd_data_p0;
            for (int i = 2; i < RD_LAT; i++) data_p[i] <= data_p[i-1];
        end

        assign fifo_push      = vld_p[RD_LAT-1];
        assign fifo_push_data = data_p[RD_LAT-1];
    end

    sram_rsp_fifo #(
        .WIDTH (BIT_PER_WORD),
        .DEPTH (CRED_MAX)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (pop),
        .out_valid (bus.rsp_valid),
        .out_data  (bus.rsp_data)
    );

endmodule

// File: tb/tb_sram_pipe.sv
// -----------------------------------------------------------------------------
// tb_sram_pipe
// Self-checking bench for sram_pipe (SEG_W=64 -> 3 mask segments, RD_LAT=2).
// A word-level reference memory predicts every read; expected responses are
// queued at acceptance and checked by an independent response monitor.
// Honours SRAM_PIPE_CLEAR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_sram_pipe;

    localparam int W     = 129;
    localparam int WORDS = 56;
    localparam int SEG   = 64;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] model [WORDS];
    logic [W-1:0] exp_q [$];

    bit           rnd_mode = 1'b0;
    int           last_acc_cyc;
    int           last_waits;

    bit           held = 1'b0;
    logic [W-1:0] held_data;

    sram_pipe_if #(.ADDR_W(6), .DATA_W(W), .SEG_W(SEG)) bus ();

    sram_pipe #(
        .WORD_AMOUNT  (WORDS),
        .BIT_PER_WORD (W),
        .SEG_W        (SEG),
        .RD_LAT       (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] d;
        d[31:0]   = $urandom();
        d[63:32]  = $urandom();
        d[95:64]  = $urandom();
        d[127:96] = $urandom();
        d[128]    = 1'($urandom());
        return d;
    endfunction

    // Reference behaviour of one accepted request.
    task automatic model_accept(input bit we, input int addr, input logic [W-1:0] d, input logic [2:0] m);
        if (we) begin
            if (addr < WORDS) begin
                for (int b = 0; b < W; b++) if (m[b / SEG]) model[addr][b] = d[b];
            end
        end else begin
            exp_q.push_back((addr < WORDS) ? model[addr] : '0);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input bit we, input int addr, input logic [W-1:0] d, input logic [2:0] m);
        bit acc = 1'b0;
        if (rnd_mode) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = 6'(addr);
        bus.req_wdata = d;
        bus.req_wmask = m;
        last_waits    = 0;
        for (int w = 0; w < 300 && !acc; w++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc          = 1'b1;
                last_acc_cyc = cyc;
                model_accept(we, addr, d, m);
            end else begin
                last_waits++;
            end
            @(posedge clk);
            #1;
            if (!acc && rnd_mode) bus.rsp_ready = 1'b1;
        end
        bus.req_valid = 1'b0;
        chk_i("req_accepted", int'(acc), 1);
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk_i("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < WORDS; a++) issue(1'b0, a, '0, 3'b000);
        drain();
    endtask

    task automatic release_rst();
        int n = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef SRAM_PIPE_CLEAR_EN
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else break;
        end
        chk_i("busy_cycles", n, WORDS);
        chk_i("ready_when_busy_falls", int'(bus.req_ready), 1);
        for (int a = 0; a < WORDS; a++) model[a] = '0;
`else
        @(negedge clk);
        chk_i("ready_before_first_edge", int'(bus.req_ready), 0);
        @(negedge clk);
        chk_i("ready_after_first_edge", int'(bus.req_ready), 1);
        chk_i("busy_tied_low", int'(bus.busy), n);
`endif
        @(posedge clk);
        #1;
    endtask

    // Response monitor: in-order compare against the scoreboard, plus
    // stability of a stalled response.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk_i("stall_valid_hold", int'(bus.rsp_valid), 1);
                chk_v("stall_data_hold", bus.rsp_data, held_data);
            end
            if (bus.rsp_valid) begin
                chk_i("rsp_has_expected", int'(exp_q.size() != 0), 1);
                if (bus.rsp_ready && exp_q.size() != 0) chk_v("rsp_data", bus.rsp_data, exp_q.pop_front());
            end
            held      = bus.rsp_valid && !bus.rsp_ready;
            held_data = bus.rsp_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        int           lat;
        int           n_acc;
        int           adr;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_i("reset_rsp_valid", int'(bus.rsp_valid), 0);
        chk_i("reset_req_ready", int'(bus.req_ready), 0);
`ifdef SRAM_PIPE_CLEAR_EN
        chk_i("reset_busy", int'(bus.busy), 1);
        // Abort the sweep at cycle 20, then let it run again from scratch.
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk_i("sweep_busy_mid", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk_i("sweep_abort_ready", int'(bus.req_ready), 0);
        repeat (2) @(posedge clk);
        #1;
`else
        chk_i("reset_busy", int'(bus.busy), 0);
`endif
        release_rst();

`ifdef SRAM_PIPE_CLEAR_EN
        read_all();
`endif

        // Fill every word with known data.
        bus.rsp_ready = 1'b1;
        for (int a = 0; a < WORDS; a++) issue(1'b1, a, rand_word(), 3'b111);

        // Known pattern, read latency with an idle output.
        d = 129'h1_DEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
        issue(1'b1, 5, d, 3'b111);
        issue(1'b0, 5, '0, 3'b000);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = cyc - last_acc_cyc;
                break;
            end
        end
        chk_i("read_latency", lat, LAT);
        @(posedge clk);
        #1;
        drain();

        // Segment mask: only the middle 64-bit segment cleared.
        issue(1'b1, 7, '1, 3'b111);
        issue(1'b1, 7, '0, 3'b010);
        issue(1'b0, 7, '0, 3'b000);
        drain();

        // Out-of-range address: read gives zero, write is dropped.
        issue(1'b0, 60, '0, 3'b000);
        issue(1'b1, 60, rand_word(), 3'b111);
        drain();
        read_all();

        // Credit limit with the output stalled, then in-order drain.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_wmask = '0;
        n_acc         = 0;
        adr           = 10;
        bus.req_addr  = 6'(adr);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                n_acc++;
                model_accept(1'b0, adr, '0, 3'b000);
            end
            @(posedge clk);
            #1;
            adr          = 10 + n_acc * 3;
            bus.req_addr = 6'(adr);
        end
        bus.req_valid = 1'b0;
        chk_i("stalled_accept_count", n_acc, LAT + 1);
        @(negedge clk);
        chk_i("stalled_req_ready", int'(bus.req_ready), 0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk);
            chk_i("drain_back_to_back", int'(bus.rsp_valid), 1);
        end
        @(posedge clk);
        #1;
        drain();

        // Back-to-back reads with the output open: no request ever waits.
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, $urandom_range(0, WORDS - 1), '0, 3'b000);
            chk_i("b2b_read_waits", last_waits, 0);
        end
        drain();

        // Randomised traffic with random output stalls.
        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom()), $urandom_range(0, 63), rand_word(), 3'($urandom()));
        end
        rnd_mode = 1'b0;
        drain();

        // Reset with reads in flight: outputs drop at once, nothing stale after.
        issue(1'b0, 3, '0, 3'b000);
        issue(1'b0, 4, '0, 3'b000);
        rst = 1'b1;
        #1;
        chk_i("rst_rsp_valid_now", int'(bus.rsp_valid), 0);
        chk_i("rst_req_ready_now", int'(bus.req_ready), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        release_rst();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_i("no_stale_rsp", int'(bus.rsp_valid), 0);
        end
        @(posedge clk);
        #1;
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
